retire_map: RTL and testbench
=============================

RETIRE_MAP -- requirements
Module: retire_map

Interface
REQ-001 SHALL have parameter NUM_ARCH, default 32, the number of architectural registers.
REQ-002 SHALL have parameter PREG_W, default $clog2(core_pkg::PREGS), the physical tag width (width of core_pkg::preg_tag_t).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port commit_valid  input  ISSUE_WIDTH(2)  per-slot ROB commit valid; slot 0 is older.
REQ-006 SHALL have port commit_arch_rd  input  2x5  architectural destination per slot.
REQ-007 SHALL have port commit_phys_rd  input  2x PREG_W  physical destination per slot.
REQ-008 SHALL have port commit_exception  input  2  exception flag per slot.
REQ-009 SHALL have port free_valid  output  2  registered; returns a freed physical tag to the freelist, per slot.
REQ-010 SHALL have port free_tag  output  2x PREG_W  registered; the freed tag per slot.
REQ-011 SHALL have port rob_flush_en  output  1  registered one-cycle ROB flush pulse.
REQ-012 SHALL have port rob_flush_ptr  output  $clog2(ROB_ENTRIES)  new ROB head/tail; constant 0.
REQ-013 SHALL have port restore_valid  output  1  registered; a speculative-RAT restore beat is valid.
REQ-014 SHALL have port restore_idx  output  2x5  architectural indices of the beat.
REQ-015 SHALL have port restore_tag  output  2x PREG_W  committed mappings for restore_idx.
REQ-016 SHALL have port busy  output  1  high in FLUSH or RESTORE; the rename stage stalls on it.
REQ-017 SHALL have port retire_count  output  32  count of instructions retired without exception.

Function
REQ-018 SHALL hold the committed map amap[0..NUM_ARCH-1] of PREG_W-bit tags.
REQ-019 SHALL implement FSM states IDLE, FLUSH and RESTORE.
REQ-020 SHALL, in IDLE, process commit slot 0 and then slot 1 in the same cycle.
REQ-021 SHALL treat a slot as retiring when commit_valid=1, commit_exception=0 and no older slot in the same cycle has an exception.
REQ-022 SHALL, for a retiring slot with arch_rd!=31, set amap[rd]<=phys_rd and, next cycle, assert free_valid[j]=1 with free_tag[j]=previous mapping of rd.
REQ-023 SHALL take the previous mapping of slot 1 from slot 0's new tag when both retiring slots share the same rd, so that amap ends with slot 1's tag.
REQ-024 SHALL, for a retiring slot with arch_rd==31 (XZR), leave amap unchanged, assert no free, and still count the slot as retired.
REQ-025 SHALL increment retire_count by the number of retiring slots (0..2) and wrap modulo 2^32.
REQ-026 SHALL, on a valid slot with exception=1 in IDLE, neither map nor free nor count that slot or any younger slot, and move to FLUSH.
REQ-027 SHALL, when an exception moves the FSM to FLUSH, still apply an older retiring slot 0 in the same cycle.
REQ-028 SHALL, in FLUSH, assert rob_flush_en=1 for exactly one cycle and then move to RESTORE.
REQ-029 SHALL, in RESTORE, emit 16 consecutive beats k=0..15 with restore_valid=1, restore_idx={2k, 2k+1} and restore_tag={amap[2k], amap[2k+1]}.
REQ-030 SHALL return to IDLE after beat 15, with no gap cycles between beats.
REQ-031 SHALL ignore all commit inputs while in FLUSH or RESTORE, and SHALL hold busy=1 in those states.
REQ-032 SHALL keep free_valid and restore_valid at 0 in any cycle where the respective event does not occur, since these outputs are single-cycle pulses.
REQ-033 SHALL treat commit_valid=2'b10 (slot 1 valid without slot 0) as a legal input and process slot 1 normally.

Reset
REQ-034 SHALL, under reset, set amap[i]=i, the FSM to IDLE, free_valid=0, rob_flush_en=0, restore_valid=0, busy=0, retire_count=0, and all tag/index outputs to 0.
REQ-035 SHALL, when reset is asserted mid-RESTORE, abort the restore immediately with no further beats.
REQ-036 SHALL give reset priority over all commit and FSM activity.

Verification
REQ-037 SHALL cover dual commit: slot0 rd=3 phys=40, slot1 rd=5 phys=41 -> next cycle free_tag={3,5}, free_valid=11; amap[3]=40, amap[5]=41; retire_count=2.
REQ-038 SHALL cover same-rd pairing: slot0 rd=7 phys=50, slot1 rd=7 phys=51 -> free_tag={7,50}; amap[7]=51.
REQ-039 SHALL cover XZR: slot0 rd=31 phys=60 -> free_valid=00; amap unchanged; retire_count+1.
REQ-040 SHALL cover exception in slot 1 with slot 0 rd=2 phys=44 -> amap[2]=44, free slot0 tag=2; next cycle rob_flush_en=1, rob_flush_ptr=0; then 16 beats whose beat 1 is idx {2,3}, tag {44,3}; busy high for 17 cycles.
REQ-041 SHALL cover commits during RESTORE: commits asserted -> no frees, amap and retire_count unchanged.
REQ-042 SHALL cover reset at RESTORE beat 5 -> next cycle restore_valid=0, busy=0, amap identity.

Source files
------------

// File: rtl/retire_map.sv
// Commit-side rename map: keeps the committed arch->phys map, frees superseded tags,
// and on an exception flushes the ROB then replays the committed map into the speculative RAT.
module retire_map #(
    parameter int NUM_ARCH    = 32,
    parameter int PREGS       = 64,
    parameter int PREG_W      = $clog2(PREGS),
    parameter int ROB_ENTRIES = 32,
    parameter int ISSUE_WIDTH = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [ISSUE_WIDTH-1:0]                  commit_valid,
    input  logic [ISSUE_WIDTH-1:0][4:0]             commit_arch_rd,
    input  logic [ISSUE_WIDTH-1:0][PREG_W-1:0]      commit_phys_rd,
    input  logic [ISSUE_WIDTH-1:0]                  commit_exception,
    output logic [ISSUE_WIDTH-1:0]                  free_valid,
    output logic [ISSUE_WIDTH-1:0][PREG_W-1:0]      free_tag,
    output logic                                    rob_flush_en,
    output logic [$clog2(ROB_ENTRIES)-1:0]          rob_flush_ptr,
    output logic                                    restore_valid,
    output logic [1:0][4:0]                         restore_idx,
    output logic [1:0][PREG_W-1:0]                  restore_tag,
    output logic                                    busy,
    output logic [31:0]                             retire_count
);
    // state   | meaning
    // IDLE    | retiring commits, updating amap and freeing old tags
    // FLUSH   | one-cycle ROB flush pulse
    // RESTORE | 16 beats replaying amap pairs to the speculative RAT
    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RESTORE} state_t;

    state_t                                 state_q, state_d;
    logic [3:0]                             rem_q, rem_d;
    logic [NUM_ARCH-1:0][PREG_W-1:0]        amap_q, amap_d;
    logic [31:0]                            count_q, count_d;
    logic [ISSUE_WIDTH-1:0]                 free_valid_q, free_valid_d;
    logic [ISSUE_WIDTH-1:0][PREG_W-1:0]     free_tag_q, free_tag_d;
    logic                                   flush_q, flush_d;
    logic                                   rvalid_q, rvalid_d;
    logic [1:0][4:0]                        ridx_q, ridx_d;
    logic [1:0][PREG_W-1:0]                 rtag_q, rtag_d;
    logic                                   ret0, ret1, exc_any;
    logic [3:0]                             beat;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        amap_d       = amap_q;
        count_d      = count_q;
        free_valid_d = '0;
        free_tag_d   = '0;
        flush_d      = 1'b0;
        rvalid_d     = 1'b0;
        ridx_d       = '0;
        rtag_d       = '0;
        beat         = '0;
        ret0    = commit_valid[0] & ~commit_exception[0];
        ret1    = commit_valid[1] & ~commit_exception[1]
                  & ~(commit_valid[0] & commit_exception[0]);
        exc_any = (commit_valid[0] & commit_exception[0])
                  | (commit_valid[1] & commit_exception[1]);

        case (state_q)
            S_IDLE: begin
                if (ret0 && commit_arch_rd[0] != 5'd31) begin
                    free_valid_d[0]                = 1'b1;
                    free_tag_d[0]                  = amap_q[commit_arch_rd[0]];
                    amap_d[commit_arch_rd[0]]      = commit_phys_rd[0];
                end
                if (ret1 && commit_arch_rd[1] != 5'd31) begin
                    free_valid_d[1] = 1'b1;
                    // slot 1 supersedes slot 0's fresh mapping when both write the same rd
                    free_tag_d[1]   = (ret0 && commit_arch_rd[0] == commit_arch_rd[1])
                                      ? commit_phys_rd[0] : amap_q[commit_arch_rd[1]];
                    amap_d[commit_arch_rd[1]] = commit_phys_rd[1];
                end
                count_d = count_q + 32'(ret0) + 32'(ret1);
                if (exc_any) begin
                    state_d = S_FLUSH;
                    flush_d = 1'b1;
                end
            end
            S_FLUSH: begin
                state_d = S_RESTORE;
                rem_d   = 4'd15;
            end
            S_RESTORE: begin
                if (rem_q == 4'd0) state_d = S_IDLE;
                else               rem_d   = rem_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RESTORE) begin
            rvalid_d  = 1'b1;
            beat      = 4'd15 - rem_d;
            ridx_d[0] = {beat, 1'b0};
            ridx_d[1] = {beat, 1'b1};
            rtag_d[0] = amap_q[ridx_d[0]];
            rtag_d[1] = amap_q[ridx_d[1]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            for (int i = 0; i < NUM_ARCH; i++) amap_q[i] <= PREG_W'(i);
            count_q      <= '0;
            free_valid_q <= '0;
            free_tag_q   <= '0;
            flush_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            ridx_q       <= '0;
            rtag_q       <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            amap_q       <= amap_d;
            count_q      <= count_d;
            free_valid_q <= free_valid_d;
            free_tag_q   <= free_tag_d;
            flush_q      <= flush_d;
            rvalid_q     <= rvalid_d;
            ridx_q       <= ridx_d;
            rtag_q       <= rtag_d;
        end
    end

    assign free_valid    = free_valid_q;
    assign free_tag      = free_tag_q;
    assign rob_flush_en  = flush_q;
    assign rob_flush_ptr = '0;
    assign restore_valid = rvalid_q;
    assign restore_idx   = ridx_q;
    assign restore_tag   = rtag_q;
    assign busy          = (state_q != S_IDLE);
    assign retire_count  = count_q;
endmodule

// File: tb/tb_retire_map.sv
// Bench for retire_map: directed commit/flush/restore cases plus random commits
// compared each cycle against a sequential model of the committed map.
module tb_retire_map;
    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       commit_valid;
    logic [1:0][4:0]  commit_arch_rd;
    logic [1:0][5:0]  commit_phys_rd;
    logic [1:0]       commit_exception;
    logic [1:0]       free_valid;
    logic [1:0][5:0]  free_tag;
    logic             rob_flush_en;
    logic [4:0]       rob_flush_ptr;
    logic             restore_valid;
    logic [1:0][4:0]  restore_idx;
    logic [1:0][5:0]  restore_tag;
    logic             busy;
    logic [31:0]      retire_count;

    retire_map dut (
        .clk(clk), .reset(reset),
        .commit_valid(commit_valid), .commit_arch_rd(commit_arch_rd),
        .commit_phys_rd(commit_phys_rd), .commit_exception(commit_exception),
        .free_valid(free_valid), .free_tag(free_tag),
        .rob_flush_en(rob_flush_en), .rob_flush_ptr(rob_flush_ptr),
        .restore_valid(restore_valid), .restore_idx(restore_idx),
        .restore_tag(restore_tag), .busy(busy), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          m_amap [32];
    int          m_phase;      // 0 idle, 1 flush, 2..17 restore beat (phase-2)
    logic [31:0] m_cnt;
    logic [1:0]  e_fv;
    int          e_ft [2];
    int          e_ri [2];
    int          e_rt [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] v,
                        input logic [4:0] rd0, input logic [4:0] rd1,
                        input logic [5:0] p0, input logic [5:0] p1,
                        input logic [1:0] ex);
        int  rda [2];
        int  pa  [2];
        bit  stop;
        rda[0] = int'(rd0); rda[1] = int'(rd1);
        pa[0]  = int'(p0);  pa[1]  = int'(p1);
        reset            = rst;
        commit_valid     = v;
        commit_arch_rd   = {rd1, rd0};
        commit_phys_rd   = {p1, p0};
        commit_exception = ex;

        e_fv = 2'b00;
        e_ft = '{0, 0};
        if (rst) begin
            for (int i = 0; i < 32; i++) m_amap[i] = i;
            m_phase = 0;
            m_cnt   = 0;
        end else if (m_phase == 0) begin
            stop = 0;
            for (int j = 0; j < 2; j++) begin
                if (!stop && v[j]) begin
                    if (ex[j]) begin
                        stop    = 1;
                        m_phase = 1;
                    end else begin
                        m_cnt++;
                        if (rda[j] != 31) begin
                            e_fv[j]        = 1'b1;
                            e_ft[j]        = m_amap[rda[j]];
                            m_amap[rda[j]] = pa[j];
                        end
                    end
                end
            end
        end else if (m_phase == 17) begin
            m_phase = 0;
        end else begin
            m_phase++;
        end

        @(posedge clk);
        @(negedge clk);

        check("free_valid", 64'(free_valid), 64'(e_fv));
        for (int j = 0; j < 2; j++)
            if (e_fv[j]) check($sformatf("free_tag%0d", j), 64'(free_tag[j]), 64'(e_ft[j]));
        check("rob_flush_en", 64'(rob_flush_en), 64'(m_phase == 1));
        check("rob_flush_ptr", 64'(rob_flush_ptr), 64'd0);
        check("restore_valid", 64'(restore_valid), 64'(m_phase >= 2));
        if (m_phase >= 2) begin
            e_ri[0] = 2 * (m_phase - 2);
            e_ri[1] = e_ri[0] + 1;
            for (int j = 0; j < 2; j++) begin
                check($sformatf("restore_idx%0d", j), 64'(restore_idx[j]), 64'(e_ri[j]));
                check($sformatf("restore_tag%0d", j), 64'(restore_tag[j]), 64'(m_amap[e_ri[j]]));
            end
        end
        check("busy", 64'(busy), 64'(m_phase != 0));
        check("retire_count", 64'(retire_count), 64'(m_cnt));
    endtask

    task automatic idle(input logic rst);
        step(rst, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 2'b00);
    endtask

    initial begin
        int          busy_n;
        logic [31:0] cnt_before;
        logic [4:0]  r0, r1;
        m_phase = 0;
        m_cnt   = 0;
        for (int i = 0; i < 32; i++) m_amap[i] = i;

        idle(1'b1);
        idle(1'b1);
        check("rst_count", 64'(retire_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // dual commit, distinct rd
        step(1'b0, 2'b11, 5'd3, 5'd5, 6'd40, 6'd41, 2'b00);
        check("dual_fv", 64'(free_valid), 64'd3);
        check("dual_ft0", 64'(free_tag[0]), 64'd3);
        check("dual_ft1", 64'(free_tag[1]), 64'd5);
        check("dual_cnt", 64'(retire_count), 64'd2);

        // same rd in both slots
        step(1'b0, 2'b11, 5'd7, 5'd7, 6'd50, 6'd51, 2'b00);
        check("same_ft0", 64'(free_tag[0]), 64'd7);
        check("same_ft1", 64'(free_tag[1]), 64'd50);

        // XZR destination
        step(1'b0, 2'b01, 5'd31, 5'd0, 6'd60, 6'd0, 2'b00);
        check("xzr_fv", 64'(free_valid), 64'd0);
        check("xzr_cnt", 64'(retire_count), 64'd5);

        // slot 1 alone
        step(1'b0, 2'b10, 5'd0, 5'd9, 6'd0, 6'd33, 2'b00);
        check("s1only_ft1", 64'(free_tag[1]), 64'd9);

        // exception in slot 1 with retiring slot 0, from a fresh map
        idle(1'b1);
        step(1'b0, 2'b11, 5'd2, 5'd9, 6'd44, 6'd45, 2'b10);
        check("exc_fv", 64'(free_valid), 64'd1);
        check("exc_ft0", 64'(free_tag[0]), 64'd2);
        check("exc_flush", 64'(rob_flush_en), 64'd1);
        busy_n     = busy ? 1 : 0;
        cnt_before = retire_count;
        for (int i = 0; i < 16; i++) begin
            r0 = 5'($urandom_range(0, 31));
            r1 = 5'($urandom_range(0, 31));
            step(1'b0, 2'($urandom), r0, r1, 6'($urandom), 6'($urandom), 2'($urandom));
            if (busy) busy_n++;
            if (i == 1) begin
                check("beat1_idx0", 64'(restore_idx[0]), 64'd2);
                check("beat1_idx1", 64'(restore_idx[1]), 64'd3);
                check("beat1_tag0", 64'(restore_tag[0]), 64'd44);
                check("beat1_tag1", 64'(restore_tag[1]), 64'd3);
            end
        end
        check("restore_cnt_held", 64'(retire_count), 64'(cnt_before));
        idle(1'b0);
        check("busy_cycles", 64'(busy_n), 64'd17);
        check("busy_done", 64'(busy), 64'd0);

        // reset in the middle of a restore
        step(1'b0, 2'b01, 5'd4, 5'd0, 6'd20, 6'd0, 2'b01);
        for (int i = 0; i < 6; i++) idle(1'b0);
        check("beat5_idx0", 64'(restore_idx[0]), 64'd10);
        idle(1'b1);
        check("rst_mid_rv", 64'(restore_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        idle(1'b0);
        check("rst_mid_rv2", 64'(restore_valid), 64'd0);
        step(1'b0, 2'b01, 5'd3, 5'd0, 6'd12, 6'd0, 2'b00);
        check("rst_mid_identity", 64'(free_tag[0]), 64'd3);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r0 = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 31));
            step($urandom_range(0, 199) == 0, 2'($urandom),
                 r0, r1, 6'($urandom), 6'($urandom),
                 {$urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
